// File: rtl/spi_flash_rd_seq.sv
// rtl/spi_flash_rd_seq.sv - Wishbone sequencer driving an SPI master through a serial-flash READ and streaming bytes out
// Each bus access idles one cycle with stb low before asserting, so back-to-back accesses always have a gap.
module spi_flash_rd_seq #(
    parameter logic [2:0] ADR_TXRX = 3'd3,
    parameter logic [2:0] ADR_CMD  = 3'd4,
    parameter logic [2:0] ADR_CS   = 3'd5,
    parameter logic [7:0] CMD_WR   = 8'h10,
    parameter logic [7:0] CMD_RD   = 8'h20,
    parameter logic [7:0] CS_MASK  = 8'h01,
    parameter int         TMO_W    = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [23:0] flash_addr_i,
    input  logic [15:0] byte_cnt_i,
    output logic [7:0]  rd_data_o,
    output logic        rd_valid_o,
    input  logic        rd_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [2:0]  wb_adr_o,
    output logic [7:0]  wb_dat_o,
    input  logic [7:0]  wb_dat_i,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    input  logic        tip_i
);

    typedef enum logic [3:0] {
        S_IDLE, S_CS_ON, S_TX_LOAD, S_TX_CMD, S_TX_WAIT, S_RX_CMD,
        S_RX_WAIT, S_RX_FETCH, S_OUT_HOLD, S_CS_OFF, S_DONE
    } state_t;

    state_t             state_q;
    state_t             wait_next;
    logic [23:0]        addr_q;
    logic [15:0]        cnt_q;
    logic [1:0]         hdr_q;
    logic [1:0]         ign_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               abort_q;
    logic               stb_q, we_q, busy_q, done_q, err_q, rd_valid_q;
    logic [2:0]         adr_q;
    logic [7:0]         dat_q, rd_data_q;

    logic               bus_st, req_we, acked, abort_now, wait_done;
    logic [2:0]         req_adr;
    logic [7:0]         req_dat, hdr_byte;

    assign acked     = stb_q & wb_ack_i;
    assign abort_now = abort_q | abort_i;
    assign wait_done = (ign_q == 2'd0) & ~tip_i;

    always_comb begin
        hdr_byte = 8'h03;
        case (hdr_q)
            2'd1:    hdr_byte = addr_q[23:16];
            2'd2:    hdr_byte = addr_q[15:8];
            2'd3:    hdr_byte = addr_q[7:0];
            default: hdr_byte = 8'h03;
        endcase
        bus_st  = 1'b1;
        req_adr = ADR_CS;
        req_dat = 8'h00;
        req_we  = 1'b1;
        case (state_q)
            S_CS_ON:    req_dat = CS_MASK;
            S_TX_LOAD:  begin req_adr = ADR_TXRX; req_dat = hdr_byte; end
            S_TX_CMD:   begin req_adr = ADR_CMD;  req_dat = CMD_WR;   end
            S_RX_CMD:   begin req_adr = ADR_CMD;  req_dat = CMD_RD;   end
            S_RX_FETCH: begin req_adr = ADR_TXRX; req_we  = 1'b0;     end
            S_CS_OFF:   req_dat = 8'h00;
            default:    bus_st = 1'b0;
        endcase
    end

    // A pending abort is only honoured once the SPI transfer has finished.
    always_comb begin
        wait_next = S_RX_CMD;
        if (abort_now)                 wait_next = S_CS_OFF;
        else if (state_q == S_RX_WAIT) wait_next = S_RX_FETCH;
        else if (hdr_q != 2'd3)        wait_next = S_TX_LOAD;
        else if (cnt_q == 16'd0)       wait_next = S_CS_OFF;
        else                           wait_next = S_RX_CMD;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= 24'd0;
            cnt_q      <= 16'd0;
            hdr_q      <= 2'd0;
            ign_q      <= 2'd0;
            tmo_q      <= '0;
            abort_q    <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= 3'd0;
            dat_q      <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'd0;
        end else begin
            done_q <= 1'b0;
            if (abort_i && state_q != S_IDLE) abort_q <= 1'b1;
            if (bus_st && !stb_q) begin
                stb_q <= 1'b1;
                adr_q <= req_adr;
                dat_q <= req_dat;
                we_q  <= req_we;
            end
            if (acked) stb_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        addr_q  <= flash_addr_i;
                        cnt_q   <= byte_cnt_i;
                        hdr_q   <= 2'd0;
                        err_q   <= 1'b0;
                        abort_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_CS_ON;
                    end
                end
                S_CS_ON:   if (acked) state_q <= abort_now ? S_CS_OFF : S_TX_LOAD;
                S_TX_LOAD: if (acked) state_q <= abort_now ? S_CS_OFF : S_TX_CMD;
                S_TX_CMD, S_RX_CMD: begin
                    if (acked) begin
                        ign_q   <= 2'd2;
                        tmo_q   <= '0;
                        state_q <= (state_q == S_TX_CMD) ? S_TX_WAIT : S_RX_WAIT;
                    end
                end
                S_TX_WAIT, S_RX_WAIT: begin
                    tmo_q <= tmo_q + TMO_W'(1);
                    if (ign_q != 2'd0) ign_q <= ign_q - 2'd1;
                    if (wait_done) begin
                        state_q <= wait_next;
                        if (state_q == S_TX_WAIT) hdr_q <= hdr_q + 2'd1;
                    end else if (tmo_q == '1) begin
                        err_q   <= 1'b1;
                        state_q <= S_CS_OFF;
                    end
                end
                S_RX_FETCH: begin
                    if (acked) begin
                        rd_data_q <= wb_dat_i;
                        if (abort_now) begin
                            state_q <= S_CS_OFF;
                        end else begin
                            rd_valid_q <= 1'b1;
                            state_q    <= S_OUT_HOLD;
                        end
                    end
                end
                S_OUT_HOLD: begin
                    if (rd_ready_i) begin
                        rd_valid_q <= 1'b0;
                        cnt_q      <= cnt_q - 16'd1;
                        state_q    <= (abort_now || cnt_q == 16'd1) ? S_CS_OFF : S_RX_CMD;
                    end else if (abort_now) begin
                        rd_valid_q <= 1'b0;
                        state_q    <= S_CS_OFF;
                    end
                end
                S_CS_OFF: begin
                    if (acked) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_we_o    = we_q;
    assign wb_stb_o   = stb_q;
    assign wb_cyc_o   = stb_q;

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// tb/tb_spi_flash_rd_seq.sv - scoreboard bench for spi_flash_rd_seq against a behavioural SPI master model
module tb_spi_flash_rd_seq;
    localparam int TMO_W = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, abort = 1'b0, rd_ready = 1'b0;
    logic [23:0] faddr = 24'd0;
    logic [15:0] bcnt = 16'd0;
    logic [7:0]  rd_data, wb_dat_o, wb_dat_i;
    logic        rd_valid, busy, done, err, wb_we, wb_stb, wb_cyc, wb_ack, tip;
    logic [2:0]  wb_adr;

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int ack_lat = 0, age = 0, tip_len = 8, tip_cnt = 0, ready_mode = 0, hold_cnt = 0;
    logic ack_r = 1'b0, tip_r = 1'b0, tip_stuck = 1'b0, stuck_arm = 1'b0;
    logic [7:0] rx_reg = 8'h5A;
    logic [10:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    int cyc = 0, done_cnt = 0, byte_cnt = 0, valid_cyc = 0, rdcmd_cnt = 0, wr_cnt = 0;
    int rdcmd_cyc = 0, err_cyc = -1, stab_viol = 0, rxcmd_viol = 0, bus_viol = 0;
    logic prev_valid = 1'b0, prev_stb = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic [11:0] prev_bus = 12'd0;

    assign wb_ack   = wb_stb & ((ack_lat == 0) | ack_r);
    assign tip      = tip_r | tip_stuck;
    assign wb_dat_i = rx_reg;

    spi_flash_rd_seq #(.TMO_W(TMO_W)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .abort_i(abort),
        .flash_addr_i(faddr), .byte_cnt_i(bcnt), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .rd_ready_i(rd_ready), .busy_o(busy), .done_o(done), .err_o(err),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we),
        .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc), .wb_ack_i(wb_ack), .tip_i(tip)
    );

    // One clock of the SPI-master/Wishbone-slave/sink model; scoreboard pops happen as the DUT produces output.
    task automatic tick();
        logic       ack_now;
        logic [10:0] ew;
        logic [7:0]  eb;
        @(posedge clk); #1;
        cyc++;
        if (tip_cnt > 0) tip_cnt--;
        tip_r = (tip_cnt > 0);
        if (ready_mode == 0) rd_ready = 1'b1;
        else if (rd_valid && hold_cnt < 20) begin rd_ready = 1'b0; hold_cnt++; end
        else begin rd_ready = rd_valid; hold_cnt = 0; end
        if (rd_valid) begin
            valid_cyc++;
            if (prev_valid && rd_data !== prev_data) stab_viol++;
            if (rd_ready) begin
                byte_cnt++;
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++; $display("FAIL byte_unexpected got %02h want none", rd_data);
                end else begin
                    eb = exp_rd.pop_front();
                    if (rd_data !== eb) begin errors++; $display("FAIL byte_data got %02h want %02h", rd_data, eb); end
                end
            end
        end
        prev_valid = rd_valid & ~rd_ready;
        prev_data  = rd_data;
        if (done) done_cnt++;
        if (err && err_cyc < 0) err_cyc = cyc;
        if (wb_stb) begin
            if (wb_cyc !== 1'b1) bus_viol++;
            if (prev_stb && {wb_adr, wb_dat_o, wb_we} !== prev_bus) bus_viol++;
            ack_now = (ack_lat == 0) || (age >= ack_lat);
            ack_r   = ack_now;
            if (ack_now) begin
                age = 0;
                if (wb_we) begin
                    wr_cnt++;
                    checks++;
                    if (exp_wr.size() == 0) begin
                        errors++; $display("FAIL bus_write_unexpected got adr %0d dat %02h want none", wb_adr, wb_dat_o);
                    end else begin
                        ew = exp_wr.pop_front();
                        if ({wb_adr, wb_dat_o} !== ew) begin
                            errors++;
                            $display("FAIL bus_write got adr %0d dat %02h want adr %0d dat %02h", wb_adr, wb_dat_o, ew[10:8], ew[7:0]);
                        end
                    end
                    if (wb_adr == 3'd4) begin
                        tip_cnt = tip_len;
                        tip_r   = 1'b1;
                        if (wb_dat_o == 8'h20) begin
                            rdcmd_cnt++;
                            rdcmd_cyc = cyc;
                            if (rd_valid) rxcmd_viol++;
                            rx_reg = {rx_reg[6:0], rx_reg[7] ^ rx_reg[5] ^ rx_reg[4] ^ rx_reg[3]};
                            if (stuck_arm) tip_stuck = 1'b1;
                        end
                    end
                end else begin
                    exp_rd.push_back(rx_reg);
                end
            end else begin
                age++;
            end
            prev_stb = ~ack_now;
            prev_bus = {wb_adr, wb_dat_o, wb_we};
        end else begin
            ack_r = 1'b0; age = 0; prev_stb = 1'b0;
        end
    endtask

    task automatic clear_counts();
        done_cnt = 0; byte_cnt = 0; valid_cyc = 0; rdcmd_cnt = 0; wr_cnt = 0; err_cyc = -1;
        stab_viol = 0; rxcmd_viol = 0; bus_viol = 0; hold_cnt = 0;
    endtask

    task automatic push_seq(input logic [23:0] a, input int nrx);
        logic [7:0] hb[4];
        hb[0] = 8'h03; hb[1] = a[23:16]; hb[2] = a[15:8]; hb[3] = a[7:0];
        exp_wr.push_back({3'd5, 8'h01});
        for (int i = 0; i < 4; i++) begin
            exp_wr.push_back({3'd3, hb[i]});
            exp_wr.push_back({3'd4, 8'h10});
        end
        for (int i = 0; i < nrx; i++) exp_wr.push_back({3'd4, 8'h20});
        exp_wr.push_back({3'd5, 8'h00});
    endtask

    task automatic run_start(input logic [23:0] a, input logic [15:0] n);
        faddr = a; bcnt = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit timed_out);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin tick(); n++; end
        timed_out = (done_cnt == 0);
        tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({busy, done, err, rd_valid, wb_stb, wb_cyc, wb_we} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 0000000", {busy, done, err, rd_valid, wb_stb, wb_cyc, wb_we});
        end
        checks++;
        if ({wb_adr, wb_dat_o, rd_data} !== 19'd0) begin
            errors++; $display("FAIL reset_data got %h want 0", {wb_adr, wb_dat_o, rd_data});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || wb_stb !== 1'b0) begin errors++; $display("FAIL reset_idle got busy %b stb %b want 0 0", busy, wb_stb); end
    endtask

    task automatic test_basic_read(input string nm);
        bit to;
        clear_counts(); ack_lat = 0; ready_mode = 0;
        push_seq(24'h012345, 4);
        run_start(24'h012345, 16'd4);
        wait_done(3000, to);
        checks++; if (to) begin errors++; $display("FAIL %s_timeout got no done want done", nm); end
        checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL %s_writes_left got %0d want 0", nm, exp_wr.size()); end
        checks++; if (byte_cnt != 4) begin errors++; $display("FAIL %s_bytes got %0d want 4", nm, byte_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done got %0d want 1", nm, done_cnt); end
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_err_busy got %b%b want 00", nm, err, busy); end
        checks++; if (bus_viol != 0) begin errors++; $display("FAIL %s_bus_hold got %0d want 0", nm, bus_viol); end
    endtask

    task automatic test_backpressure();
        bit to;
        clear_counts(); ack_lat = 2; ready_mode = 1;
        push_seq(24'hABCDEF, 3);
        run_start(24'hABCDEF, 16'd3);
        wait_done(4000, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout got no done want done"); end
        checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL bp_writes_left got %0d want 0", exp_wr.size()); end
        checks++; if (byte_cnt != 3) begin errors++; $display("FAIL bp_bytes got %0d want 3", byte_cnt); end
        checks++; if (valid_cyc != 63) begin errors++; $display("FAIL bp_valid_cycles got %0d want 63", valid_cyc); end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL bp_data_stable got %0d changes want 0", stab_viol); end
        checks++; if (rxcmd_viol != 0) begin errors++; $display("FAIL bp_rxcmd_early got %0d want 0", rxcmd_viol); end
        checks++; if (bus_viol != 0) begin errors++; $display("FAIL bp_bus_hold got %0d want 0", bus_viol); end
        ready_mode = 0;
    endtask

    task automatic test_timeout();
        bit to;
        clear_counts(); ack_lat = 1; stuck_arm = 1'b1;
        push_seq(24'h000100, 1);
        run_start(24'h000100, 16'd2);
        wait_done(2000, to);
        checks++; if (to) begin errors++; $display("FAIL tmo_timeout got no done want done"); end
        checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL tmo_writes_left got %0d want 0", exp_wr.size()); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b want 1", err); end
        checks++; if (byte_cnt != 0 || valid_cyc != 0) begin errors++; $display("FAIL tmo_bytes got %0d want 0", byte_cnt); end
        checks++;
        if (err_cyc - rdcmd_cyc < 63 || err_cyc - rdcmd_cyc > 67) begin
            errors++; $display("FAIL tmo_latency got %0d want 63..67", err_cyc - rdcmd_cyc);
        end
        stuck_arm = 1'b0; tip_stuck = 1'b0;
    endtask

    task automatic test_abort();
        bit to;
        clear_counts(); ack_lat = 0;
        push_seq(24'h7FFFFE, 2);
        run_start(24'h7FFFFE, 16'd10);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err_cleared got %b want 0", err); end
        for (int i = 0; i < 1000 && rdcmd_cnt < 2; i++) tick();
        checks++; if (rdcmd_cnt != 2) begin errors++; $display("FAIL abort_reach_rx2 got %0d want 2", rdcmd_cnt); end
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(1000, to);
        checks++; if (to) begin errors++; $display("FAIL abort_timeout got no done want done"); end
        checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL abort_writes_left got %0d want 0", exp_wr.size()); end
        checks++; if (byte_cnt != 1 || exp_rd.size() != 0) begin errors++; $display("FAIL abort_bytes got %0d want 1", byte_cnt); end
        checks++; if (done_cnt != 1 || rd_valid !== 1'b0) begin errors++; $display("FAIL abort_done got %0d valid %b want 1 0", done_cnt, rd_valid); end
    endtask

    task automatic test_zero_and_ignore();
        bit to;
        clear_counts(); ack_lat = 1;
        push_seq(24'h00FF00, 0);
        faddr = 24'h00FF00; bcnt = 16'd0; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy got %b want 1", busy); end
        tick(); tick(); tick();
        run_start(24'h112233, 16'd5);
        wait_done(2000, to);
        checks++; if (to) begin errors++; $display("FAIL zero_timeout got no done want done"); end
        checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL zero_writes_left got %0d want 0", exp_wr.size()); end
        checks++; if (valid_cyc != 0) begin errors++; $display("FAIL zero_valid got %0d want 0", valid_cyc); end
        checks++; if (done_cnt != 1 || err !== 1'b0) begin errors++; $display("FAIL zero_done got %0d err %b want 1 0", done_cnt, err); end
    endtask

    task automatic test_reset_mid();
        clear_counts(); ack_lat = 0;
        push_seq(24'h012345, 4);
        run_start(24'h012345, 16'd4);
        for (int i = 0; i < 200 && wr_cnt < 3; i++) tick();
        tick(); tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, done, err, rd_valid, wb_stb, wb_cyc, wb_we, wb_adr, wb_dat_o, rd_data} !== 26'd0) begin
            errors++; $display("FAIL rstmid_outputs got %h want 0", {busy, done, err, rd_valid, wb_stb, wb_cyc, wb_we, wb_adr, wb_dat_o, rd_data});
        end
        rst = 1'b0;
        tip_cnt = 0; tip_r = 1'b0; age = 0; ack_r = 1'b0; prev_stb = 1'b0;
        exp_wr.delete(); exp_rd.delete();
        tick();
        test_basic_read("rstmid");
    endtask

    initial begin
        test_reset();
        test_basic_read("basic");
        test_backpressure();
        test_timeout();
        test_abort();
        test_zero_and_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
